// File: rtl/wb_port_arbiter.sv
// Writeback port arbiter: two requesters (ALU "A" and load "M") share the
// single register-file write port. Round-robin between them on conflicts,
// one-hot decode of the destination, one registered output stage, and a
// saturating counter of conflict cycles for performance debug.
module wb_port_arbiter #(
    parameter int DATA_W = 16,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              flush,
    input  logic              a_valid,
    input  logic [3:0]        a_addr,
    input  logic [DATA_W-1:0] a_data,
    output logic              a_ready,
    input  logic              m_valid,
    input  logic [3:0]        m_addr,
    input  logic [DATA_W-1:0] m_data,
    output logic              m_ready,
    output logic              wr_valid,
    output logic [15:0]       wr_we,
    output logic [3:0]        wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic [CNT_W-1:0]  conflict_cnt
);

    // Which requester won the most recent handshake; the other one wins the
    // next conflict.
    typedef enum logic {
        LG_A = 1'b0,
        LG_M = 1'b1
    } last_grant_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    last_grant_t last_grant_r;
    logic        active_s;
    logic        both_s;
    logic        grant_a_s;
    logic        grant_m_s;

    // Binary register index to one-hot write enable.
    function automatic logic [15:0] decode_we(input logic [3:0] addr);
        decode_we = 16'h0001 << addr;
    endfunction

    // Combinational grant: nothing is granted during a stall or a flush.
    always_comb begin
        active_s  = en & ~flush;
        both_s    = a_valid & m_valid;
        grant_a_s = 1'b0;
        grant_m_s = 1'b0;
        if (active_s) begin
            if (both_s) begin
                grant_a_s = (last_grant_r == LG_M);
                grant_m_s = (last_grant_r == LG_A);
            end else begin
                grant_a_s = a_valid;
                grant_m_s = m_valid;
            end
        end else begin
            grant_a_s = 1'b0;
            grant_m_s = 1'b0;
        end
    end

    assign a_ready = grant_a_s;
    assign m_ready = grant_m_s;

    // Round-robin state: follows the handshake winner, flush restores LG_M so
    // that A wins the first conflict afterwards.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant_r <= LG_M;
        end else if (flush) begin
            last_grant_r <= LG_M;
        end else begin
            case (last_grant_r)
                LG_A: begin
                    if (grant_m_s) begin
                        last_grant_r <= LG_M;
                    end else begin
                        last_grant_r <= LG_A;
                    end
                end
                LG_M: begin
                    if (grant_a_s) begin
                        last_grant_r <= LG_A;
                    end else begin
                        last_grant_r <= LG_M;
                    end
                end
                default: last_grant_r <= LG_M;
            endcase
        end
    end

    // Output stage: one write per granted cycle; address and data hold when
    // idle so only the strobe and enables need to be trusted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_valid <= 1'b0;
            wr_we    <= 16'h0000;
            wr_addr  <= 4'h0;
            wr_data  <= '0;
        end else if (grant_a_s) begin
            wr_valid <= 1'b1;
            wr_we    <= decode_we(a_addr);
            wr_addr  <= a_addr;
            wr_data  <= a_data;
        end else if (grant_m_s) begin
            wr_valid <= 1'b1;
            wr_we    <= decode_we(m_addr);
            wr_addr  <= m_addr;
            wr_data  <= m_data;
        end else begin
            wr_valid <= 1'b0;
            wr_we    <= 16'h0000;
        end
    end

    // Saturating count of cycles where both requesters competed for the port;
    // stalls and flushes do not count, only reset clears it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            conflict_cnt <= '0;
        end else if (active_s && both_s && (conflict_cnt != CNT_MAX)) begin
            conflict_cnt <= conflict_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            conflict_cnt <= conflict_cnt;
        end
    end

endmodule

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
- Arbitrates the single register-file write port between two writeback requesters: ALU result (A) and load result (M).
- Decodes the granted 4-bit destination into the 16-bit one-hot write-enable bus that drives the register file.
- Registered single-stage output. Round-robin fairness with a saturating conflict counter for performance debug.
- Sits between the EX/MEM writeback stages and the register file.

Parameters:
- DATA_W, 16, width of write data.
- CNT_W, 8, width of the saturating conflict counter.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- en  in  1  global enable; low = pipeline stall, no grants issued
- flush  in  1  synchronous flush; drops the output stage and resets fairness
- a_valid  in  1  ALU writeback request
- a_addr  in  4  ALU destination register
- a_data  in  DATA_W  ALU result
- a_ready  out  1  ALU request accepted this cycle (combinational)
- m_valid  in  1  load writeback request
- m_addr  in  4  load destination register
- m_data  in  DATA_W  load result
- m_ready  out  1  load request accepted this cycle (combinational)
- wr_valid  out  1  register-file write strobe
- wr_we  out  16  one-hot write enable; bit n = register n
- wr_addr  out  4  binary destination (mirror of wr_we)
- wr_data  out  DATA_W  write data
- conflict_cnt  out  CNT_W  count of cycles with both requests valid

Behaviour:
- Reset (async, rst=1): wr_valid=0, wr_we=16'h0000, wr_addr=0, wr_data=0, conflict_cnt=0, last_grant=M, so A wins the first conflict.
- Grant logic is combinational and only active when en=1 and flush=0:
  - Only a_valid=1: grant A.
  - Only m_valid=1: grant M.
  - Both valid: grant the requester not equal to last_grant.
  - Neither valid: no grant.
- a_ready = grant_A; m_ready = grant_M. The two are never high in the same cycle. A requester holds valid, addr and data stable until its ready is seen.
- Handshake completes on the rising edge with valid & ready. last_grant updates to the winner on that edge.
- Output stage latency is 1 cycle. On the edge after a grant:
  - wr_valid=1, wr_addr=granted addr, wr_data=granted data.
  - wr_we = 1<<addr, exactly one bit set.
- If there was no grant, the next cycle has wr_valid=0 and wr_we=0. wr_addr and wr_data hold their previous values.
- Invariant: wr_we is nonzero if and only if wr_valid=1.
- en=0: both readys low and the output stage clears to wr_valid=0, wr_we=0. last_grant and conflict_cnt hold. Pending requests stay pending.
- flush=1 has priority over en:
  - Readys low.
  - wr_valid=0, wr_we=0.
  - last_grant=M, conflict_cnt holds.
- Conflict counter: increments on each cycle where en=1, flush=0 and a_valid=m_valid=1. It saturates at 2^CNT_W-1 and does not wrap. Only rst clears it.
- Same-address conflict: no merging. Both writes are issued in grant order on separate cycles, and the later write wins in the register file.
- Reset mid-operation: the output stage is dropped immediately. A write in flight is lost, and the requesters re-present after reset.
- FSM uses a 1-bit state last_grant with states {LG_A, LG_M}:
  - LG_A -> LG_M on an M handshake.
  - LG_M -> LG_A on an A handshake.
  - Any state -> LG_M on flush or rst.

Test Plan:
- Reset then idle: rst pulse, no requests -> all outputs 0, conflict_cnt=0 for 10 cycles.
- Single requester: a_valid=1, a_addr=4'h5, a_data=16'hBEEF, en=1 -> a_ready=1 same cycle. Next cycle wr_valid=1, wr_we=16'h0020, wr_addr=5, wr_data=16'hBEEF.
- Conflict alternation: both valid for 4 cycles, a_addr=1, m_addr=2 -> grants A,M,A,M; wr_we sequence 0002,0004,0002,0004; conflict_cnt=4.
- Stall: both valid, en=0 for 3 cycles -> readys 0, wr_valid=0, conflict_cnt unchanged. On en=1 the grant resumes with the correct round-robin winner.
- Flush after an M grant: assert flush, then both valid -> A granted first. The cycle after flush has wr_valid=0 and wr_we=0.
- Saturation and async reset: CNT_W=2, 5 conflict cycles -> conflict_cnt=3. Assert rst mid-cycle -> outputs clear immediately, without waiting for a clock edge.
